// File: rtl/apb_master_queued.sv
// APB4 requester fed by a valid/ready command FIFO, with a one-entry response
// register that reports read data, slave error and wait-state timeout.
module apb_master_queued #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           pclk_i,
  input  logic                           prstn_i,
  output logic [ADDR_WIDTH-1:0]          paddr_o,
  output logic [2:0]                     pprot_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [DATA_WIDTH-1:0]          pwdata_o,
  output logic [DATA_WIDTH/8-1:0]        pstrb_o,
  input  logic                           pready_i,
  input  logic [DATA_WIDTH-1:0]          prdata_i,
  input  logic                           pslverr_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        cmd_strb_i,
  input  logic                           cmd_write_i,
  input  logic [2:0]                     cmd_prot_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic                           rsp_timeout_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_level_o,
  output logic                           busy_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int LVL_W  = $clog2(CMD_DEPTH + 1);
  localparam int ENT_W  = ADDR_WIDTH + DATA_WIDTH + STRB_W + 1 + 3;
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [ENT_W-1:0]      r_fifo [CMD_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [1:0]            r_state;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [2:0]            r_pprot;
  logic                  r_psel, r_penable, r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic                  r_rsp_valid, r_rsp_err, r_rsp_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_cmd_ready, w_push, w_start;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic [STRB_W-1:0]     w_head_strb;
  logic                  w_head_write;
  logic [2:0]            w_head_prot;

  assign w_cmd_ready = (r_level != LVL_W'(CMD_DEPTH));
  assign w_push      = cmd_valid_i && w_cmd_ready;
  // A transfer only starts when its response cannot overwrite an unread one.
  assign w_start     = (r_state == S_IDLE) && (r_level != '0) &&
                       (!r_rsp_valid || rsp_ready_i);

  assign {w_head_addr, w_head_wdata, w_head_strb, w_head_write, w_head_prot} = r_fifo[r_rd_ptr];

  // NOTE: FIFO storage is deliberately not reset; the pointers and level define validity.
  always_ff @(posedge pclk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= {cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_write_i, cmd_prot_i};
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_paddr       <= '0;
      r_pprot       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_start) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_start)      r_level <= r_level + 1'b1;
      else if (!w_push && w_start) r_level <= r_level - 1'b1;

      if (r_rsp_valid && rsp_ready_i) r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_paddr    <= w_head_addr;
            r_pprot    <= w_head_prot;
            r_pwrite   <= w_head_write;
            r_pwdata   <= w_head_write ? w_head_wdata : '0;
            r_pstrb    <= w_head_write ? w_head_strb : '0;
            r_psel     <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= pslverr_i;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_pwrite && !pslverr_i) ? prdata_i : '0;
          end else if ((TIMEOUT_CYCLES != 0) && (r_wait_cnt == WAIT_LAST)) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_IDLE;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign paddr_o       = r_paddr;
  assign pprot_o       = r_pprot;
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign pwrite_o      = r_pwrite;
  assign pwdata_o      = r_pwdata;
  assign pstrb_o       = r_pstrb;
  assign cmd_ready_o   = w_cmd_ready;
  assign cmd_level_o   = r_level;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;
  assign busy_o        = (r_state != S_IDLE) || (r_level != '0) || r_rsp_valid;

endmodule

// File: doc/apb_master_queued.md
Name: apb_master_queued

Overview:
- Parametrised APB4 requester with a CMD_DEPTH-deep command FIFO, per-transfer byte strobes and protection attributes, and a one-entry response register.
- The response register reports read data, PSLVERR and a wait-state timeout.
- Sits between CSR/firmware-facing logic and an APB slave fabric.
- Replaces single-shot pulse-triggered control with a valid/ready queue, so software can post several accesses without polling idle.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (8, 16 or 32)
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 256, max ACCESS wait cycles before abort (0 = disabled)

Ports:
pclk_i  in  1  clock
prstn_i  in  1  asynchronous active-low reset
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction (1 = write)
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB write strobes
pready_i  in  1  slave ready
prdata_i  in  DATA_WIDTH  slave read data
pslverr_i  in  1  slave error
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  FIFO not full
cmd_addr_i  in  ADDR_WIDTH  command address
cmd_wdata_i  in  DATA_WIDTH  command write data
cmd_strb_i  in  DATA_WIDTH/8  command write strobes
cmd_write_i  in  1  1 = write, 0 = read
cmd_prot_i  in  3  command protection
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes, errors and timeouts)
rsp_err_o  out  1  PSLVERR or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
cmd_level_o  out  $clog2(CMD_DEPTH+1)  FIFO occupancy
busy_o  out  1  FIFO non-empty, transfer in flight, or response pending

Behaviour:
- Reset (prstn_i low, asynchronous): FSM returns to IDLE and the FIFO is emptied.
  - All APB outputs, rsp_* outputs and cmd_level_o are 0; busy_o is 0; cmd_ready_o is 1.
  - A transfer in flight is dropped with no response.
- Command FIFO:
  - A command is pushed when cmd_valid_i && cmd_ready_o; cmd_ready_o = (level != CMD_DEPTH).
  - Push and pop in the same cycle leaves the level unchanged.
  - Read/write pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when level > 0 and the response slot is free (rsp_valid_o == 0, or rsp_valid_o && rsp_ready_i this cycle).
    - On this edge the FIFO head is popped and registered into paddr/pprot/pwrite/pwdata/pstrb, and psel_o is set to 1.
    - Reads drive pwdata_o = 0 and pstrb_o = 0.
  - SETUP -> ACCESS unconditionally; penable_o is set to 1.
  - ACCESS, pready_i = 1 (completion): psel_o and penable_o go to 0, FSM goes to IDLE.
    - Response register loads rsp_rdata_o = (read && !pslverr_i) ? prdata_i : 0, rsp_err_o = pslverr_i, rsp_timeout_o = 0; rsp_valid_o is set.
    - paddr/pwrite/pprot/pwdata/pstrb hold their last values.
  - ACCESS, pready_i = 0: wait counter increments.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, the transfer is aborted the same as a completion, but with rdata = 0, err = 1 and timeout = 1.
    - The wait counter clears on entry to SETUP.
- Between transfers, at least one IDLE cycle with psel_o = 0.
  - Best throughput is one transfer per 3 cycles when rsp_ready_i is held high.
- Latency: a command pushed at edge E0 into an empty FIFO with a free response slot gives SETUP after E1 and ACCESS after E2. With zero wait states, rsp_valid_o rises after E3.
- Response: rsp_valid_o clears on rsp_valid_o && rsp_ready_i unless reloaded. The FSM never starts a transfer that could overwrite an unconsumed response.
- APB4 compliance: address, control, pwdata and pstrb are stable from SETUP through ACCESS completion.
- busy_o = (state != IDLE) || (level != 0) || rsp_valid_o.

Test Plan:
- Single write: push addr 0x100, wdata 0xDEADBEEF, strb 0xF, prot 3'b010, pready tied high -> SETUP at cycle 2, ACCESS at cycle 3 with pwrite = 1 and pstrb = 0xF; rsp_valid with err = 0, rdata = 0.
- Read with 2 wait states: slave returns 0x12345678 on the third ACCESS cycle -> penable high for 3 cycles, pstrb = 0; rsp_rdata = 0x12345678.
- Queue fill: push 5 commands with CMD_DEPTH = 4 and rsp_ready_i = 0 -> cmd_ready_o drops at level 4; first response is held, no second SETUP until rsp_ready_i = 1; all 5 complete in order.
- Slave error: pslverr_i = 1 on a read completion -> rsp_err = 1, rsp_rdata = 0, next queued command proceeds.
- Timeout: TIMEOUT_CYCLES = 8, pready_i held low -> psel_o/penable_o drop after 8 ACCESS cycles; rsp_err = 1, rsp_timeout = 1.
- Reset mid-ACCESS with 2 commands queued -> all outputs 0, cmd_level_o = 0, no response produced; a new command after reset completes normally.
